// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl
// IF-stage fetch sequencer. Owns the program counter, boots from boot_addr_i,
// and issues one outstanding instruction-memory request at a time over a
// req/gnt/rvalid handshake. Redirects (pc_set_i) replace the PC and cause any
// response already in flight to be dropped. Fetched words are held for decode
// under a valid/ready handshake.
//
// Parameters
//   ADDR_W : address / PC width
//   INC    : sequential PC increment in bytes
//
// Ports
//   clk_i, rst_ni          : clock (rising edge), async active-low reset
//   fetch_enable_i         : allow fetching (sampled in IDLE and on HOLD exit)
//   boot_addr_i            : first fetch address after reset
//   pc_set_i, pc_target_i  : one-cycle redirect request and its target
//   instr_req_o/addr_o     : memory request and address (address = PC)
//   instr_gnt_i            : request accepted
//   instr_rvalid_i/rdata_i : response valid and data
//   instr_valid_o          : instruction available to decode
//   instr_rdata_o/pc_o     : held instruction and its PC
//   id_ready_i             : decode accepts the instruction
//   fetch_err_o            : sticky misaligned-redirect error
//
// Build option
//   IF_FETCH_CTRL_ALIGN_CHK_EN : when defined, a misaligned redirect is
//   rejected, raises fetch_err_o until reset, and parks the FSM in IDLE once
//   nothing is outstanding. When undefined, the target's low two bits are
//   cleared on load and fetch_err_o is tied low.
// ---------------------------------------------------------------------------
module if_fetch_ctrl #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INC    = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              fetch_enable_i,
  input  logic [ADDR_W-1:0] boot_addr_i,
  input  logic              pc_set_i,
  input  logic [ADDR_W-1:0] pc_target_i,
  output logic              instr_req_o,
  output logic [ADDR_W-1:0] instr_addr_o,
  input  logic              instr_gnt_i,
  input  logic              instr_rvalid_i,
  input  logic [31:0]       instr_rdata_i,
  output logic              instr_valid_o,
  output logic [31:0]       instr_rdata_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              id_ready_i,
  output logic              fetch_err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              booted_q, booted_d;
  logic              kill_q, kill_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;

  logic [ADDR_W-1:0] target_s;  // redirect target as it would be loaded
  logic              bad_s;     // redirect target rejected as misaligned
  logic              load_s;    // redirect actually updates the PC
  logic              stop_s;    // error present: never start another request

`ifdef IF_FETCH_CTRL_ALIGN_CHK_EN
  logic err_q;

  assign target_s = pc_target_i;
  assign bad_s    = pc_set_i && (pc_target_i[1:0] != 2'b00);
  // Redirects are only honoured outside IDLE, so only there can they fault.
  assign stop_s   = err_q || (bad_s && (state_q != IDLE));

  // Sticky misaligned-redirect error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q || (bad_s && (state_q != IDLE));
    end
  end

  assign fetch_err_o = err_q;
`else
  assign target_s    = pc_target_i & {{(ADDR_W-2){1'b1}}, 2'b00};
  assign bad_s       = 1'b0;
  assign stop_s      = 1'b0;
  assign fetch_err_o = 1'b0;
`endif

  assign load_s = pc_set_i && !bad_s;

  // Next-state, PC and instruction-buffer logic.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    booted_d = booted_q;
    kill_d   = kill_q;
    rdata_d  = rdata_q;
    ipc_d    = ipc_q;

    case (state_q)
      IDLE: begin
        if (fetch_enable_i && !stop_s) begin
          state_d = REQ;
          if (!booted_q) begin
            pc_d     = boot_addr_i;
            booted_d = 1'b1;
          end else begin
            pc_d = pc_q;
          end
        end else begin
          state_d = IDLE;
        end
      end

      REQ: begin
        if (instr_gnt_i) begin
          // The grant belongs to the old address; a same-cycle redirect
          // (valid or rejected) must discard its response.
          state_d = WAIT;
          kill_d  = pc_set_i;
        end else if (stop_s) begin
          state_d = IDLE;
        end else begin
          state_d = REQ;
        end
        if (load_s) begin
          pc_d = target_s;
        end else begin
          pc_d = pc_q;
        end
      end

      WAIT: begin
        if (instr_rvalid_i) begin
          if (kill_q || pc_set_i) begin
            kill_d  = 1'b0;
            state_d = stop_s ? IDLE : REQ;
            if (load_s) begin
              pc_d = target_s;
            end else begin
              pc_d = pc_q;
            end
          end else begin
            rdata_d = instr_rdata_i;
            ipc_d   = pc_q;
            pc_d    = pc_q + ADDR_W'(INC);
            state_d = HOLD;
          end
        end else if (pc_set_i) begin
          kill_d = 1'b1;
          if (load_s) begin
            pc_d = target_s;
          end else begin
            pc_d = pc_q;
          end
        end else begin
          state_d = WAIT;
        end
      end

      HOLD: begin
        // Redirect wins over decode acceptance and kills the held word.
        if (pc_set_i) begin
          state_d = stop_s ? IDLE : REQ;
          if (load_s) begin
            pc_d = target_s;
          end else begin
            pc_d = pc_q;
          end
        end else if (id_ready_i) begin
          state_d = (fetch_enable_i && !stop_s) ? REQ : IDLE;
        end else begin
          state_d = HOLD;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, PC and instruction-buffer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      booted_q <= 1'b0;
      kill_q   <= 1'b0;
      rdata_q  <= 32'h0000_0000;
      ipc_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      booted_q <= booted_d;
      kill_q   <= kill_d;
      rdata_q  <= rdata_d;
      ipc_q    <= ipc_d;
    end
  end

  assign instr_req_o   = (state_q == REQ);
  assign instr_valid_o = (state_q == HOLD);
  assign instr_addr_o  = pc_q;
  assign instr_rdata_o = rdata_q;
  assign instr_pc_o    = ipc_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_ctrl
// Self-checking bench for if_fetch_ctrl. A transaction-level model (flags for
// "request presented", "response outstanding", "word held") predicts every
// output each cycle; a bench-side memory answers requests with data derived
// from the granted address so that data/PC pairing can be checked too.
// Directed scenarios with literal expectations pin the model, then a random
// phase exercises arbitrary handshake timing and redirects.
// ---------------------------------------------------------------------------
module tb_if_fetch_ctrl;

`ifdef IF_FETCH_CTRL_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        fetch_enable_i;
  logic [31:0] boot_addr_i;
  logic        pc_set_i;
  logic [31:0] pc_target_i;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_valid_o;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_pc_o;
  logic        id_ready_i;
  logic        fetch_err_o;

  always #5 clk_i = ~clk_i;

  if_fetch_ctrl dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .fetch_enable_i (fetch_enable_i),
    .boot_addr_i    (boot_addr_i),
    .pc_set_i       (pc_set_i),
    .pc_target_i    (pc_target_i),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .instr_valid_o  (instr_valid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_pc_o     (instr_pc_o),
    .id_ready_i     (id_ready_i),
    .fetch_err_o    (fetch_err_o)
  );

  int checks = 0;
  int errors = 0;

  // model state
  logic [31:0] m_pc, m_data, m_ipc, m_gaddr;
  bit          m_booted, m_req, m_out, m_drop, m_hold, m_err;
  int          cyc = 0;
  logic [31:0] gnt_log[$];
  logic [31:0] acc_log[$];
  int          acc_cyc[$];

  // memory / decode behaviour (percent probabilities)
  int gnt_pct = 100, rv_pct = 100, rdy_pct = 100, spur_pct = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  function automatic bit pct(input int p);
    return ($urandom_range(0, 99) < p);
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < 0 || i >= q.size()) return 32'hDEAD_BEEF;
    return q[i];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_data = 32'h0; m_ipc = 32'h0; m_gaddr = 32'h0;
    m_booted = 1'b0; m_req = 1'b0; m_out = 1'b0; m_drop = 1'b0;
    m_hold = 1'b0; m_err = 1'b0;
  endtask

  // Advance the model by one clock using the inputs sampled at the edge.
  task automatic model_update();
    logic [31:0] t;
    bit bad, ld, idle;
    cyc++;
    if (!rst_ni) begin
      model_reset();
      return;
    end
    t    = ALIGN_CHK ? pc_target_i : {pc_target_i[31:2], 2'b00};
    bad  = ALIGN_CHK && pc_set_i && (pc_target_i[1:0] != 2'b00);
    ld   = pc_set_i && !bad;
    idle = !(m_req || m_out || m_hold);
    if (bad && !idle) m_err = 1'b1;
    if (m_hold) begin
      if (pc_set_i) begin
        m_hold = 1'b0; m_req = 1'b1;
        if (ld) m_pc = t;
      end else if (id_ready_i) begin
        acc_log.push_back(m_ipc);
        acc_cyc.push_back(cyc);
        m_hold = 1'b0; m_req = fetch_enable_i;
      end
    end else if (m_req) begin
      if (instr_gnt_i) begin
        gnt_log.push_back(m_pc);
        m_gaddr = m_pc; m_req = 1'b0; m_out = 1'b1; m_drop = pc_set_i;
      end
      if (ld) m_pc = t;
    end else if (m_out) begin
      if (instr_rvalid_i) begin
        m_out = 1'b0;
        if (m_drop || pc_set_i) begin
          m_drop = 1'b0; m_req = 1'b1;
        end else begin
          m_data = instr_rdata_i; m_ipc = m_pc; m_pc = m_pc + 32'd4; m_hold = 1'b1;
        end
      end else if (pc_set_i) begin
        m_drop = 1'b1;
      end
      if (ld) m_pc = t;
    end else begin
      if (fetch_enable_i && !m_err) begin
        m_req = 1'b1;
        if (!m_booted) begin
          m_pc = boot_addr_i; m_booted = 1'b1;
        end
      end
    end
    if (m_err) m_req = 1'b0;
  endtask

  task automatic compare();
    chk("req", instr_req_o, m_req);
    chk("addr", instr_addr_o, m_pc);
    chk("valid", instr_valid_o, m_hold);
    chk("rdata", instr_rdata_o, m_data);
    chk("ipc", instr_pc_o, m_ipc);
    chk("err", fetch_err_o, m_err);
    if (instr_valid_o) chk("data_pc_pair", instr_rdata_o, memf(instr_pc_o));
  endtask

  // Memory and decode reactions, driven away from the active edge.
  task automatic mem_drive();
    instr_gnt_i = instr_req_o && pct(gnt_pct);
    if (m_out && pct(rv_pct)) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = memf(m_gaddr);
    end else begin
      instr_rvalid_i = !m_out && pct(spur_pct);
      instr_rdata_i  = $urandom;
    end
    id_ready_i  = pct(rdy_pct);
    pc_set_i    = 1'b0;
    pc_target_i = $urandom;
  endtask

  task automatic step();
    @(posedge clk_i);
    model_update();
    @(negedge clk_i);
    compare();
    mem_drive();
  endtask

  // kind 0: response for addr outstanding, 1: request presented, 2: any outstanding
  task automatic wait_model(input int kind, input logic [31:0] addr, input string name);
    bit hit;
    int n;
    n = 0;
    hit = (kind == 0) ? (m_out && m_gaddr == addr) : (kind == 1) ? m_req : m_out;
    while (!hit && n < 60) begin
      step();
      n++;
      hit = (kind == 0) ? (m_out && m_gaddr == addr) : (kind == 1) ? m_req : m_out;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s timeout actual=not-reached required=reached", name);
    end
  endtask

  // Called at a falling edge; reset is held across one rising edge.
  task automatic do_reset(input logic [31:0] boot);
    rst_ni = 1'b0;
    model_reset();
    fetch_enable_i = 1'b0; pc_set_i = 1'b0; instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b0; boot_addr_i = boot;
    #1;
    chk("rst_req", instr_req_o, 32'd0);
    chk("rst_valid", instr_valid_o, 32'd0);
    chk("rst_addr", instr_addr_o, 32'd0);
    chk("rst_rdata", instr_rdata_o, 32'd0);
    chk("rst_ipc", instr_pc_o, 32'd0);
    chk("rst_err", fetch_err_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    int gi, ai;
    logic [31:0] tgt;
    rst_ni = 1'b0; fetch_enable_i = 1'b0; boot_addr_i = 32'h80;
    pc_set_i = 1'b0; pc_target_i = 32'h0; instr_gnt_i = 1'b0;
    instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0; id_ready_i = 1'b1;
    @(negedge clk_i);
    do_reset(32'h80);

    // Boot and sequential fetch, ideal memory and decode.
    fetch_enable_i = 1'b1;
    gnt_log.delete(); acc_log.delete(); acc_cyc.delete();
    repeat (9) step();
    chk("boot_gnt_count", gnt_log.size(), 32'd3);
    chk("boot_gnt0", qget(gnt_log, 0), 32'h80);
    chk("boot_gnt1", qget(gnt_log, 1), 32'h84);
    chk("boot_gnt2", qget(gnt_log, 2), 32'h88);
    chk("boot_acc0_pc", qget(acc_log, 0), 32'h80);
    chk("boot_acc1_pc", qget(acc_log, 1), 32'h84);
    chk("boot_throughput", (acc_cyc.size() > 1) ? acc_cyc[1] - acc_cyc[0] : 0, 32'd3);

    // Decode backpressure while 0x88 is held.
    rdy_pct = 0; id_ready_i = 1'b0;
    chk("bp_valid0", instr_valid_o, 32'd1);
    repeat (5) begin
      step();
      chk("bp_valid", instr_valid_o, 32'd1);
      chk("bp_req", instr_req_o, 32'd0);
      chk("bp_pc", instr_pc_o, 32'h88);
      chk("bp_data", instr_rdata_o, memf(32'h88));
    end
    rdy_pct = 100;

    // Redirect in WAIT while 0x84 is outstanding.
    do_reset(32'h80);
    fetch_enable_i = 1'b1;
    wait_model(0, 32'h84, "wait_0x84");
    gi = gnt_log.size(); ai = acc_log.size();
    instr_rvalid_i = 1'b0; pc_set_i = 1'b1; pc_target_i = 32'h200;
    repeat (8) step();
    chk("rw_next_gnt", qget(gnt_log, gi), 32'h200);
    chk("rw_next_acc", qget(acc_log, ai), 32'h200);

    // Redirect and grant in the same cycle.
    wait_model(1, 32'h0, "wait_req_sc");
    gi = gnt_log.size(); ai = acc_log.size();
    instr_gnt_i = 1'b1; pc_set_i = 1'b1; pc_target_i = 32'h300;
    repeat (8) step();
    chk("sc_next_gnt", qget(gnt_log, gi + 1), 32'h300);
    chk("sc_next_acc", qget(acc_log, ai), 32'h300);

    // Wrap past the top of the address space.
    wait_model(1, 32'h0, "wait_req_wrap");
    gi = gnt_log.size();
    instr_gnt_i = 1'b0; pc_set_i = 1'b1; pc_target_i = 32'hFFFF_FFFC;
    repeat (10) step();
    chk("wrap_gnt0", qget(gnt_log, gi), 32'hFFFF_FFFC);
    chk("wrap_gnt1", qget(gnt_log, gi + 1), 32'h0);

    // Reset mid-WAIT, then a late response while idle.
    wait_model(2, 32'h0, "wait_out_rst");
    do_reset(32'h80);
    fetch_enable_i = 1'b0; spur_pct = 100; instr_rvalid_i = 1'b1;
    repeat (3) begin
      step();
      chk("idle_after_rst_req", instr_req_o, 32'd0);
      chk("idle_after_rst_valid", instr_valid_o, 32'd0);
    end
    spur_pct = 0;

`ifdef IF_FETCH_CTRL_ALIGN_CHK_EN
    // Misaligned redirect while a response is outstanding.
    do_reset(32'h80);
    fetch_enable_i = 1'b1;
    wait_model(2, 32'h0, "wait_out_mis");
    gi = gnt_log.size();
    instr_rvalid_i = 1'b0; pc_set_i = 1'b1; pc_target_i = 32'h102;
    repeat (10) step();
    chk("mis_err", fetch_err_o, 32'd1);
    chk("mis_req", instr_req_o, 32'd0);
    chk("mis_no_gnt", gnt_log.size() - gi, 32'd0);
    chk("mis_addr_kept", instr_addr_o == 32'h102, 32'd0);
`endif

    // Random handshake timing, enables and redirects.
    for (int blk = 0; blk < 3; blk++) begin
      do_reset($urandom & 32'hFFFF_FFFC);
      fetch_enable_i = 1'b1;
      ai = acc_log.size();
      for (int i = 0; i < 1000; i++) begin
        if (i % 200 == 0) begin
          gnt_pct  = $urandom_range(20, 100);
          rv_pct   = $urandom_range(20, 100);
          rdy_pct  = $urandom_range(20, 100);
          spur_pct = $urandom_range(0, 10);
        end
        step();
        if (pct(3)) fetch_enable_i = ~fetch_enable_i;
        if (pct(4)) begin
          tgt = $urandom;
          if (ALIGN_CHK) tgt = tgt & 32'hFFFF_FFFC;
          pc_set_i = 1'b1; pc_target_i = tgt;
        end
      end
      chk("rand_progress", acc_log.size() > ai, 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Fetch sequencer for the IF stage. Owns the program counter, starts from the boot address, and issues single-outstanding requests to instruction memory using a req/gnt/rvalid handshake. Redirects on `pc_set_i` and discards stale responses. Presents each fetched instruction, with its PC, to decode under a valid/ready handshake.

## Interface
- `ADDR_W`, 32, address and PC width
- `INC`, 4, sequential PC increment in bytes
- `clk_i`  in  1  clock, rising edge
- `rst_ni`  in  1  asynchronous active-low reset
- `fetch_enable_i`  in  1  allow fetching
- `boot_addr_i`  in  ADDR_W  first fetch address after reset
- `pc_set_i`  in  1  redirect request, one-cycle pulse
- `pc_target_i`  in  ADDR_W  redirect target, valid with `pc_set_i`
- `instr_req_o`  out  1  memory request
- `instr_addr_o`  out  ADDR_W  request address, equals `pc_q`
- `instr_gnt_i`  in  1  request accepted
- `instr_rvalid_i`  in  1  response valid
- `instr_rdata_i`  in  32  response data
- `instr_valid_o`  out  1  instruction available to decode
- `instr_rdata_o`  out  32  registered instruction
- `instr_pc_o`  out  ADDR_W  PC of `instr_rdata_o`
- `id_ready_i`  in  1  decode accepts instruction
- `fetch_err_o`  out  1  misaligned-redirect error; see Configuration

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD. Internal state: `pc_q`, `booted_q`, `kill_q`.
- **IDLE**
  - No request is issued.
  - On `fetch_enable_i=1`: go to REQ.
  - If `booted_q=0`: also load `pc_q<=boot_addr_i` and set `booted_q<=1`. If `booted_q=1`, `pc_q` is kept.
- **REQ**
  - `instr_req_o=1`, `instr_addr_o=pc_q`.
  - `instr_gnt_i=1`: go to WAIT.
  - `pc_set_i=1` without gnt: `pc_q<=pc_target_i`, stay in REQ. The address changes on the next cycle.
  - `pc_set_i=1` with gnt in the same cycle: the grant applies to the old address. Set `kill_q<=1`, load `pc_q<=pc_target_i`, go to WAIT.
- **WAIT**
  - `instr_req_o=0`.
  - `pc_set_i` without rvalid: `pc_q<=pc_target_i`, `kill_q<=1`.
  - `instr_rvalid_i` with `kill_q=1` or `pc_set_i=1`:
    - discard the data and clear `kill_q`
    - apply any same-cycle redirect
    - go to REQ
  - `instr_rvalid_i` otherwise:
    - `instr_rdata_o<=instr_rdata_i`, `instr_pc_o<=pc_q`
    - `pc_q<=pc_q+INC`, modulo 2^ADDR_W (wraps silently)
    - go to HOLD
- **HOLD**
  - `instr_valid_o=1`. Data and PC are stable until the instruction is consumed.
  - `pc_set_i=1` has priority over `id_ready_i`: the instruction is killed, `pc_q<=pc_target_i`, go to REQ.
  - `id_ready_i=1`: go to REQ if `fetch_enable_i=1`, else go to IDLE.
- `fetch_enable_i` is sampled only in IDLE and on HOLD exit. An in-flight transaction always completes.
- Reset values:
  - state IDLE
  - `pc_q`, `instr_addr_o`, `instr_rdata_o`, `instr_pc_o` all 0
  - `instr_req_o`, `instr_valid_o`, `fetch_err_o` all 0
  - `booted_q=0`, `kill_q=0`
- Reset asserted mid-transaction returns to IDLE immediately. A late `instr_rvalid_i` arriving in IDLE is ignored.

## Timing
- `instr_req_o` and `instr_valid_o` are decoded from the registered state, so there is no combinational path from any input.
- Best case per instruction: REQ (gnt) → WAIT (rvalid) → HOLD (ready). Throughput is 1 instruction per 3 cycles.
- From `fetch_enable_i` rising in IDLE, `instr_req_o` rises on the next cycle.
- After `pc_set_i` in HOLD, `instr_addr_o=pc_target_i` with `instr_req_o=1` on the next cycle.
- `instr_rvalid_i` outside WAIT is ignored.

## Configuration
- Macro: `IF_FETCH_CTRL_ALIGN_CHK_EN`.
- **Defined:**
  - `pc_set_i` with `pc_target_i[1:0]!=0` is not applied.
  - `fetch_err_o` goes high and stays high until reset.
  - The FSM goes to IDLE once any outstanding response has been received or dropped, and then ignores `fetch_enable_i`.
- **Not defined:**
  - `pc_target_i[1:0]` is forced to 00 when loaded.
  - `fetch_err_o` is tied to 0.

## Test plan
- **Boot and sequential fetch:** `boot_addr_i=0x80`, enable; memory grants immediately, rvalid 1 cycle later, ready always high. Required: addresses 0x80, 0x84, 0x88 in order; `instr_pc_o` matches each address; one instruction every 3 cycles.
- **Decode backpressure:** `id_ready_i=0` for 5 cycles in HOLD. Required: `instr_valid_o` held, data and PC stable, `instr_req_o=0`.
- **Redirect in WAIT:** `pc_set_i` with target 0x200 while a fetch of 0x84 is outstanding. Required: the 0x84 response is dropped; the next request is to 0x200; `instr_pc_o=0x200`.
- **Redirect and grant in the same cycle:** `pc_set_i` (0x300) and `instr_gnt_i` together in REQ. Required: the old response is discarded; the next request is to 0x300.
- **Wrap and reset:** `pc_set_i` to 0xFFFF_FFFC, then fetch twice. Required: the second address is 0x0. Then assert `rst_ni=0` mid-WAIT. Required: all outputs 0 and the FSM in IDLE.
- **Macro defined, misaligned redirect:** `pc_set_i` to 0x102. Required: `fetch_err_o=1` sticky; no request to 0x102; the FSM stays in IDLE with `fetch_enable_i=1`.
